// File: rtl/icache_axi_reader_pkg.sv
// Shared definitions for the instruction-cache line refill path: FSM states,
// AXI encodings and cache-line geometry.
package icache_axi_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int LINE_WORDS  = 8;
  localparam int OFFSET_BITS = 5;
  localparam int BEAT_BITS   = 3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_LINE   = 8'd7;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/icache_axi_reader.sv
// Refills one instruction-cache line through a single 8-beat AXI INCR read
// burst and hands the assembled line to the cache with a one-cycle grant.
module icache_axi_reader #(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_req,
  input  logic [31:0]                  rd_addr,
  output logic                         gnt,
  output logic [LINE_WORDS-1:0][31:0]  line_data,
  output logic                         err,
  output logic [3:0]                   arid,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic [1:0]                   arlock,
  output logic [3:0]                   arcache,
  output logic [2:0]                   arprot,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [3:0]                   rid,
  input  logic [31:0]                  rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready
);
  import icache_axi_reader_pkg::*;

  localparam logic [BEAT_BITS-1:0] BEAT_MAX = BEAT_BITS'(LINE_WORDS - 1);

  state_e                      state_q, state_d;
  logic [31:0]                 addr_q, addr_d;
  logic [BEAT_BITS-1:0]        beat_q, beat_d;
  logic                        err_flag_q, err_flag_d;
  logic [LINE_WORDS-1:0][31:0] line_q, line_d;
  logic                        arvalid_q, rready_q, gnt_q, err_q;

  // Only one burst is ever outstanding, so the read ID carries no information.
  logic unused_rid;
  assign unused_rid = ^rid;

  // Next-state, address latch, beat counter, error accumulation and line buffer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    err_flag_d = err_flag_q;
    line_d     = line_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          addr_d     = line_base(rd_addr);
          beat_d     = {BEAT_BITS{1'b0}};
          err_flag_d = 1'b0;
          state_d    = ST_AR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        if (arready) begin
          state_d = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_R: begin
        if (rvalid) begin
          // Extra beats land on the last word; completion follows rlast alone.
          line_d[beat_q] = rdata;
          beat_d         = (beat_q == BEAT_MAX) ? beat_q : beat_q + 3'd1;
          err_flag_d     = err_flag_q | resp_is_err(rresp);
          state_d        = rlast ? ST_DONE : ST_R;
        end else begin
          state_d = ST_R;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath registers and registered handshake/grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'd0;
      beat_q     <= {BEAT_BITS{1'b0}};
      err_flag_q <= 1'b0;
      line_q     <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      gnt_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      err_flag_q <= err_flag_d;
      line_q     <= line_d;
      arvalid_q  <= (state_d == ST_AR);
      rready_q   <= (state_d == ST_R);
      gnt_q      <= (state_d == ST_DONE);
      err_q      <= (state_d == ST_DONE) & err_flag_d;
    end
  end

  assign arid      = AXI_ID;
  assign araddr    = addr_q;
  assign arlen     = AXI_LEN_LINE;
  assign arsize    = AXI_SIZE_4B;
  assign arburst   = AXI_BURST_INCR;
  assign arlock    = 2'b00;
  assign arcache   = 4'b0000;
  assign arprot    = 3'b000;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign gnt       = gnt_q;
  assign err       = err_q;
  assign line_data = line_q;

endmodule

// File: tb/tb_icache_axi_reader.sv
// Scoreboard bench for icache_axi_reader: the stimulus process plays cache and
// AXI slave and queues expected bursts/lines; a negedge monitor checks them.
module tb_icache_axi_reader;

  logic             clk = 1'b0;
  logic             rst;
  logic             rd_req;
  logic [31:0]      rd_addr;
  logic             gnt;
  logic [7:0][31:0] line_data;
  logic             err;
  logic [3:0]       arid;
  logic [31:0]      araddr;
  logic [7:0]       arlen;
  logic [2:0]       arsize;
  logic [1:0]       arburst;
  logic [1:0]       arlock;
  logic [3:0]       arcache;
  logic [2:0]       arprot;
  logic             arvalid;
  logic             arready;
  logic [3:0]       rid;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rlast;
  logic             rvalid;
  logic             rready;

  icache_axi_reader #(.LINE_WORDS(8), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .gnt(gnt),
    .line_data(line_data), .err(err), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0][31:0] line;
    logic             err;
    int               gcyc;
  } exp_t;

  exp_t             line_q[$];
  logic [31:0]      ar_q[$];
  logic [7:0][31:0] model;
  int               checks = 0;
  int               errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: address channel, grant/line scoreboard, pulse width and hold.
  logic gnt_prev  = 1'b0;
  logic stab_pend = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      gnt_prev  = 1'b0;
      stab_pend = 1'b0;
    end else begin
      if (arvalid) begin
        if (ar_q.size() == 0) begin
          chk("ar_unexpected", 32'd1, 32'd0);
        end else begin
          chk("araddr", araddr, ar_q[0]);
          if (arready) begin
            chk("arlen", {24'd0, arlen}, 32'd7);
            chk("arsize", {29'd0, arsize}, 32'd2);
            chk("arburst", {30'd0, arburst}, 32'd1);
            chk("ar_id_lock_cache_prot", {19'd0, arid, arlock, arcache, arprot}, 32'd0);
            void'(ar_q.pop_front());
          end
        end
      end
      if (rvalid && !rready) chk("rready_on_beat", {31'd0, rready}, 32'd1);
      if (gnt) begin
        chk("gnt_single_pulse", {31'd0, gnt_prev}, 32'd0);
        if (line_q.size() == 0) begin
          chk("gnt_unexpected", 32'd1, 32'd0);
        end else begin
          cur = line_q.pop_front();
          for (int k = 0; k < 8; k++) chk($sformatf("line_data[%0d]", k), line_data[k], cur.line[k]);
          chk("err_at_gnt", {31'd0, err}, {31'd0, cur.err});
          chk("gnt_cycle", cyc, cur.gcyc);
          stab_pend = 1'b1;
        end
      end else begin
        if (err) chk("err_without_gnt", {31'd0, err}, 32'd0);
        if (stab_pend) begin
          for (int k = 0; k < 8; k++) chk($sformatf("line_hold[%0d]", k), line_data[k], cur.line[k]);
          stab_pend = 1'b0;
        end
      end
      gnt_prev = gnt;
    end
  end

  // One refill: request, AR handshake after ar_delay cycles, nbeats R beats
  // (optionally gapped), optional bad response, optional reset at beat rst_at.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] exp_araddr,
                        input logic [31:0] dbase, input int nbeats, input int ar_delay,
                        input bit gap, input int bad_beat, input bit drop_in_ar,
                        input bit chk_lat, input int rst_at);
    int   req_cyc;
    bit   seen;
    logic e;
    exp_t x;
    rd_req  = 1'b1;
    rd_addr = addr;
    req_cyc = cyc;
    e       = 1'b0;
    ar_q.push_back(exp_araddr);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      seen = arvalid;
    end
    if (!seen) begin
      chk("arvalid_timeout", 32'd0, 32'd1);
      rd_req = 1'b0;
      return;
    end
    if (drop_in_ar) rd_req = 1'b0;
    repeat (ar_delay) begin @(posedge clk); #1; end
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (gap && i > 0) begin @(posedge clk); #1; end
      if (i == rst_at) begin
        rst = 1'b1;
        #2;
        chk("rst_gnt", {31'd0, gnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_line[%0d]", k), line_data[k], 32'd0);
        model  = '0;
        rd_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      rvalid = 1'b1;
      rdata  = dbase + 32'(i);
      rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
      rlast  = (i == nbeats - 1);
      model[(i > 7) ? 7 : i] = dbase + 32'(i);
      if (i == bad_beat) e = 1'b1;
      @(posedge clk); #1;
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
    end
    x.line = model;
    x.err  = e;
    x.gcyc = chk_lat ? req_cyc + 10 : cyc;
    line_q.push_back(x);
    @(posedge clk); #1;
    if (!drop_in_ar) begin
      chk("no_burst_from_done_cycle", {31'd0, arvalid}, 32'd0);
      rd_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = 32'd0; arready = 1'b0;
    rid = 4'h5; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    model = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_arvalid", {31'd0, arvalid}, 32'd0);
    chk("reset_rready", {31'd0, rready}, 32'd0);
    chk("reset_gnt", {31'd0, gnt}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_araddr", araddr, 32'd0);
    for (int k = 0; k < 8; k++) chk($sformatf("reset_line[%0d]", k), line_data[k], 32'd0);
    rst = 1'b0;
    // addr, araddr, data base, beats, ar delay, gap, bad beat, drop, latency, rst beat
    do_req(32'h1FC0_0024, 32'h1FC0_0020, 32'h100, 8, 0, 1'b0, -1, 1'b0, 1'b1, -1);
    do_req(32'h0000_1234, 32'h0000_1220, 32'h200, 8, 5, 1'b1, -1, 1'b0, 1'b0, -1);
    do_req(32'h8000_0000, 32'h8000_0000, 32'h300, 8, 0, 1'b0,  3, 1'b0, 1'b0, -1);
    do_req(32'h8000_003C, 32'h8000_0020, 32'h400, 8, 2, 1'b0, -1, 1'b1, 1'b0, -1);
    do_req(32'hABCD_EF60, 32'hABCD_EF60, 32'h500, 6, 0, 1'b0, -1, 1'b0, 1'b0, -1);
    do_req(32'h0000_0100, 32'h0000_0100, 32'h600, 8, 0, 1'b0, -1, 1'b0, 1'b0,  4);
    do_req(32'h0000_0040, 32'h0000_0040, 32'h700, 8, 0, 1'b0, -1, 1'b0, 1'b1, -1);
    do_req(32'h0000_0080, 32'h0000_0080, 32'h800, 10, 1, 1'b0, -1, 1'b0, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    chk("lines_outstanding", line_q.size(), 32'd0);
    chk("ar_outstanding", ar_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
